// File: rtl/demux_route_pkg.sv
// demux_route_pkg
// Shared types and helpers for the 1:8 demux routing controller.
//   route_state_t : controller FSM state (IDLE / SEND)
//   NCH, SEL_W    : channel count and select width
//   onehot8()     : select value to one-hot channel mask
package demux_route_pkg;

    typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} route_state_t;

    localparam int NCH   = 8;
    localparam int SEL_W = 3;

    function automatic logic [NCH-1:0] onehot8(input logic [SEL_W-1:0] sel);
        logic [NCH-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/demux_route_wait_cnt.sv
// demux_route_wait_cnt
// Counts SEND cycles spent waiting on a channel and flags the cycle on which
// the wait budget is exhausted.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the count (new beat accepted); wins over inc
//   inc        : one more cycle waited without completion
//   expire     : count has reached TIMEOUT-1, i.e. this is the last allowed cycle
module demux_route_wait_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign expire = (cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/demux_route_ctrl.sv
// demux_route_ctrl
// Sequences a 1:8 demultiplexer: accepts (data, dest) beats on a valid/ready
// input, holds each beat on sel/en/out_data until the addressed channel takes
// it, and drops beats aimed at disabled (or, optionally, stalled) channels.
// Build option: define DEMUX_ROUTE_TIMEOUT_EN to drop beats that wait TIMEOUT
// SEND cycles; without it SEND waits indefinitely on out_ready.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : upstream handshake, in_data/in_dest sampled on accept
//   ch_en               : per-channel enable mask
//   out_ready           : per-channel downstream ready
//   sel, en, out_data   : demux controls and data
//   out_valid           : one-hot valid, en << sel
//   drop, drop_cnt      : dropped-beat pulse and saturating count
module demux_route_ctrl
    import demux_route_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [2:0]        in_dest,
    input  logic [7:0]        ch_en,
    input  logic [7:0]        out_ready,
    output logic [2:0]        sel,
    output logic              en,
    output logic [DATA_W-1:0] out_data,
    output logic [7:0]        out_valid,
    output logic              drop,
    output logic [7:0]        drop_cnt
);

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("demux_route_ctrl: TIMEOUT must be within 2..255");
    end

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    route_state_t state;
    logic         in_send;
    logic         complete;
    logic         chan_off;
    logic         timed_out;
    logic         drop_now;
    logic         accept;

    assign in_send  = (state == SEND);
    assign complete = in_send & out_ready[sel] & ch_en[sel];
    assign chan_off = in_send & ~ch_en[sel];

`ifdef DEMUX_ROUTE_TIMEOUT_EN
    logic expire;

    demux_route_wait_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (accept),
        .inc    (in_send & ~complete),
        .expire (expire)
    );

    // Completion in the expiry cycle wins: only an unfinished wait times out.
    assign timed_out = in_send & ~complete & expire;
`else
    assign timed_out = 1'b0;
`endif

    // chan_off already implies no completion, so at most one drop per cycle.
    assign drop_now = chan_off | timed_out;

    // Ready mid-SEND only on completion, giving 1 beat/cycle streaming.
    assign in_ready = ~in_send | complete;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel      <= '0;
            out_data <= '0;
            drop     <= 1'b0;
            drop_cnt <= '0;
        end else begin
            drop <= drop_now;
            if (drop_now) begin
                drop_cnt <= sat_inc(drop_cnt);
            end
            // sel/out_data load only on accept so sel never moves between beats.
            if (accept) begin
                state    <= SEND;
                sel      <= in_dest;
                out_data <= in_data;
            end else if (complete || drop_now) begin
                state <= IDLE;
            end
        end
    end

    assign en        = in_send;
    assign out_valid = in_send ? onehot8(sel) : 8'h00;

endmodule

// File: tb/tb_demux_route_ctrl.sv
// tb_demux_route_ctrl
// Directed-vector bench for demux_route_ctrl with a transaction-level model
// (one held beat, a wait age, a drop tally) compared against the DUT on every
// falling clock edge, plus literal expectations at key points of each scenario.
// Follows DEMUX_ROUTE_TIMEOUT_EN in the same way as the design.
module tb_demux_route_ctrl;

    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 16;
`ifdef DEMUX_ROUTE_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [2:0]        in_dest;
    logic [7:0]        ch_en;
    logic [7:0]        out_ready;
    logic [2:0]        sel;
    logic              en;
    logic [DATA_W-1:0] out_data;
    logic [7:0]        out_valid;
    logic              drop;
    logic [7:0]        drop_cnt;

    demux_route_ctrl #(
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .ch_en     (ch_en),
        .out_ready (out_ready),
        .sel       (sel),
        .en        (en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .drop      (drop),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int n_del  = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: at most one beat is in flight; it leaves when its channel takes
    // it, when the channel is disabled, or when its wait budget runs out.
    bit         m_busy = 1'b0;
    logic [2:0] m_dest = '0;
    logic [7:0] m_data = '0;
    int         m_wait = 0;
    bit         m_drop = 1'b0;
    int         m_cnt  = 0;

    always @(posedge clk or negedge rst_n) begin
        bit deliver, dropping, ready;
        if (!rst_n) begin
            m_busy = 1'b0; m_dest = '0; m_data = '0;
            m_wait = 0;    m_drop = 1'b0; m_cnt = 0;
        end else begin
            deliver  = m_busy && out_ready[m_dest] && ch_en[m_dest];
            dropping = m_busy && !deliver &&
                       (!ch_en[m_dest] || (TO_ON && m_wait == TIMEOUT - 1));
            ready    = !m_busy || deliver;
            m_drop   = dropping;
            if (dropping && m_cnt < 255) m_cnt++;
            if (in_valid && ready) begin
                m_busy = 1'b1; m_dest = in_dest; m_data = in_data; m_wait = 0;
            end else if (deliver || dropping) begin
                m_busy = 1'b0;
            end else if (m_busy) begin
                m_wait++;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("cmp_en",        32'(en),        32'(m_busy));
            chk("cmp_sel",       32'(sel),       32'(m_dest));
            chk("cmp_out_data",  32'(out_data),  32'(m_data));
            chk("cmp_out_valid", 32'(out_valid), m_busy ? (32'd1 << m_dest) : 32'd0);
            chk("cmp_drop",      32'(drop),      32'(m_drop));
            chk("cmp_drop_cnt",  32'(drop_cnt),  32'(m_cnt));
            chk("cmp_in_ready",  32'(in_ready),
                32'(!m_busy || (out_ready[m_dest] && ch_en[m_dest])));
            if (rst_n && en && out_ready[sel] && ch_en[sel]) n_del++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int exp_cnt;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_dest = '0;
        ch_en = 8'hFF; out_ready = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        started = 1'b1;
        chk("rst_en",        32'(en),        32'd0);
        chk("rst_sel",       32'(sel),       32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_drop_cnt",  32'(drop_cnt),  32'd0);
        rst_n = 1'b1;
        step();

        // Back-to-back beats A0..A7 to channels 0..7.
        base = n_del;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 8'(8'hA0 + i); in_dest = 3'(i);
            step();
            chk("t1_out_valid", 32'(out_valid), 32'd1 << i);
            chk("t1_out_data",  32'(out_data),  32'hA0 + 32'(i));
            chk("t1_in_ready",  32'(in_ready),  32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("t1_idle_en",   32'(en),           32'd0);
        chk("t1_delivered", 32'(n_del - base), 32'd8);
        chk("t1_drop_cnt",  32'(drop_cnt),     32'd0);

        // Channel 5 stalls for four SEND cycles, then takes the beat.
        base = n_del;
        out_ready = 8'hDF;
        in_valid = 1'b1; in_data = 8'h3C; in_dest = 3'd5;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t2_out_valid", 32'(out_valid), 32'h20);
            chk("t2_in_ready",  32'(in_ready),  32'd0);
            step();
        end
        out_ready = 8'hFF;
        #1;
        chk("t2_out_valid_last", 32'(out_valid), 32'h20);
        chk("t2_in_ready_last",  32'(in_ready),  32'd1);
        step();
        chk("t2_delivered", 32'(n_del - base), 32'd1);
        chk("t2_drop",      32'(drop),         32'd0);

        // Disabled channel 2: one SEND cycle, then a one-cycle drop pulse.
        ch_en = 8'hFB;
        in_valid = 1'b1; in_data = 8'h77; in_dest = 3'd2;
        step();
        in_valid = 1'b0;
        chk("t3_in_ready",  32'(in_ready),  32'd0);
        chk("t3_out_valid", 32'(out_valid), 32'h04);
        step();
        chk("t3_drop",     32'(drop),     32'd1);
        chk("t3_drop_cnt", 32'(drop_cnt), 32'd1);
        chk("t3_en",       32'(en),       32'd0);
        step();
        chk("t3_drop_off", 32'(drop), 32'd0);
        ch_en = 8'hFF;
        exp_cnt = 1;

        // Channel 7 never ready.
        out_ready = 8'h00;
        in_valid = 1'b1; in_data = 8'h99; in_dest = 3'd7;
        step();
        in_valid = 1'b0;
        if (TO_ON) begin
            repeat (15) step();
            chk("t4_still_held", 32'(en),   32'd1);
            chk("t4_no_drop",    32'(drop), 32'd0);
            step();
            exp_cnt = 2;
            chk("t4_drop",     32'(drop),     32'd1);
            chk("t4_drop_cnt", 32'(drop_cnt), 32'(exp_cnt));
            chk("t4_en",       32'(en),       32'd0);
            out_ready = 8'hFF;
        end else begin
            repeat (100) step();
            chk("t4_held_en",        32'(en),        32'd1);
            chk("t4_held_sel",       32'(sel),       32'd7);
            chk("t4_held_out_valid", 32'(out_valid), 32'h80);
            chk("t4_held_drop_cnt",  32'(drop_cnt),  32'(exp_cnt));
            out_ready = 8'hFF;
            step();
            chk("t4_release_en", 32'(en), 32'd0);
        end

        // Channel 1 becomes ready exactly on the 16th SEND cycle.
        base = n_del;
        out_ready = 8'h00;
        in_valid = 1'b1; in_data = 8'h11; in_dest = 3'd1;
        step();
        in_valid = 1'b0;
        repeat (15) step();
        out_ready = 8'hFF;
        #1;
        chk("t5_in_ready", 32'(in_ready), 32'd1);
        step();
        chk("t5_drop",      32'(drop),         32'd0);
        chk("t5_drop_cnt",  32'(drop_cnt),     32'(exp_cnt));
        chk("t5_delivered", 32'(n_del - base), 32'd1);

        // Reset in the middle of a SEND wait.
        out_ready = 8'h00;
        in_valid = 1'b1; in_data = 8'h55; in_dest = 3'd3;
        step();
        in_valid = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_en",        32'(en),        32'd0);
        chk("t6_sel",       32'(sel),       32'd0);
        chk("t6_out_data",  32'(out_data),  32'd0);
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_drop",      32'(drop),      32'd0);
        chk("t6_drop_cnt",  32'(drop_cnt),  32'd0);
        step();
        rst_n = 1'b1;
        out_ready = 8'hFF;
        step();

        // 300 drops on a disabled channel: count saturates at 255.
        ch_en = 8'h00;
        in_valid = 1'b1; in_data = 8'hEE; in_dest = 3'd0;
        repeat (20) step();
        chk("t7_drop_cnt_10", 32'(drop_cnt), 32'd10);
        repeat (580) step();
        in_valid = 1'b0;
        step();
        step();
        chk("t7_drop_cnt_sat", 32'(drop_cnt), 32'd255);
        ch_en = 8'hFF;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_route_ctrl.md
Name: demux_route_ctrl

Overview:
- Controller that sequences a 1:8 demultiplexer datapath.
- Accepts a stream of (data, destination) beats on a valid/ready input and drives sel/en/data for the 1:8 demux.
- Holds each beat until the addressed output channel is ready, and drops beats aimed at disabled or stalled channels.
- Sits between an upstream producer and eight downstream consumers; it is the only agent that changes demux sel.

Parameters:
- DATA_W, 8, width of the routed data word.
- TIMEOUT, 16, maximum SEND cycles spent waiting on a channel before the beat is dropped (legal range 2..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  controller can accept a beat.
- in_data  input  DATA_W  upstream data.
- in_dest  input  3  destination channel 0..7.
- ch_en  input  8  per-channel enable mask; bit i=0 means channel i is disabled.
- out_ready  input  8  per-channel downstream ready.
- sel  output  3  demux select.
- en  output  1  demux enable.
- out_data  output  DATA_W  data presented to the demux input.
- out_valid  output  8  one-hot valid; equals en<<sel.
- drop  output  1  one-cycle pulse on each dropped beat.
- drop_cnt  output  8  dropped-beat count, saturates at 255.

Behaviour:
- Reset (async assert, synchronous release): state=IDLE, sel=0, en=0, out_data=0, out_valid=0, drop=0, drop_cnt=0, wait counter=0.
- State IDLE:
  - in_ready=1, en=0.
  - On in_valid&&in_ready: register in_data and in_dest into the hold registers, clear the wait counter, go to SEND.
- State SEND:
  - en=1, sel=held dest, out_data=held data, out_valid=onehot(held dest).
  - Completion when out_ready[sel]=1 and ch_en[sel]=1. The beat is delivered in that cycle.
  - in_ready = completion (combinational), so back-to-back beats move at 1 beat/cycle. A beat accepted in a completion cycle reloads the hold registers and stays in SEND; otherwise go to IDLE.
- Disabled channel:
  - If ch_en[sel]=0 in any SEND cycle, the beat is dropped in that cycle: drop asserted next cycle, drop_cnt incremented, go to IDLE, in_ready=0 that cycle.
  - out_valid still shows the beat for that one cycle, but consumers must gate with ch_en.
- Timeout:
  - The wait counter increments each SEND cycle without completion.
  - When counter==TIMEOUT-1 with no completion, the beat is dropped as above.
- Single drop source per cycle, so drop_cnt increments by at most 1 per cycle and holds at 255.
- Simultaneous out_ready and a timeout expiry in the same cycle: completion wins and there is no drop.
- in_dest and in_data are sampled only on the accept handshake. Later changes to these inputs have no effect on a held beat.
- ch_en or out_ready changing mid-wait is evaluated each cycle; there is no latching.
- rst_n asserted mid-SEND discards the held beat immediately, with no drop pulse and no count.
- sel holds its last value in IDLE, so sel does not glitch between beats.

Optional Feature:
- Macro: DEMUX_ROUTE_TIMEOUT_EN.
- Defined: timeout drop logic as above.
- Undefined:
  - No wait counter is built, and SEND waits indefinitely for out_ready[sel].
  - Disabled-channel drops still occur.
  - TIMEOUT is ignored.

Decomposition:
- Package demux_route_pkg holds:
  - typedef enum logic [0:0] {IDLE, SEND} route_state_t;
  - localparam NCH=8;
  - localparam SEL_W=3;
  - function onehot8(sel) returning the 8-bit one-hot.
- One natural sub-module: demux_route_wait_cnt, holding the timeout counter with clear, increment and expire outputs. It is instantiated only under DEMUX_ROUTE_TIMEOUT_EN.
- The 1:8 demux itself stays outside and is driven by sel/en/out_data.

Test Plan:
- Reset, all out_ready=1, ch_en=8'hFF, beats data 8'hA0..8'hA7 to dest 0..7 back-to-back → each beat appears one cycle after accept with out_valid=8'h01,02,..,80. in_ready stays high; 8 beats take 9 cycles; drop_cnt=0.
- Send dest=5 data=8'h3C with out_ready[5]=0 for 4 cycles, then 1 → en=1, sel=5, out_valid=8'h20 held for 5 cycles, in_ready low for those 4 cycles. Delivered once; no drop.
- ch_en=8'hFB, send dest=2 → one SEND cycle, then drop=1 for one cycle, drop_cnt=1, state back to IDLE.
- With DEMUX_ROUTE_TIMEOUT_EN and TIMEOUT=16, dest=7, out_ready=0 forever → drop on the 16th SEND cycle and drop_cnt increments. Without the macro the beat is still held after 100 cycles.
- Stall dest=1 until cycle 15, then raise out_ready[1] exactly on the expiry cycle → delivered, no drop.
- Assert rst_n=0 mid-SEND → all outputs zero immediately, drop_cnt=0. Force 300 drops → drop_cnt saturates at 255.
